bp_lite_mem_latency_model: RTL
==============================

Name: bp_lite_mem_latency_model

Overview:
- Bedrock-lite memory endpoint for tethered testbenches, directly downstream of the top-level wrapper's mem_cmd_o/mem_resp_i port pair.
- Accepts one full-block command message per handshake and applies it to an internal block-wide memory array.
- Returns responses in order after a programmable fixed latency, with up to els_p commands outstanding.

Parameters:
- paddr_width_p, 40, physical address width.
- data_width_p, 512, block data width in bits; power of 2, at least 64.
- mem_els_p, 1024, number of block-wide memory words; power of 2.
- els_p, 4, maximum number of outstanding commands (queue depth); at least 2.
- latency_p, 8, cycles from command acceptance to response valid; at least 1.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- mem_cmd_i  in  hdr_w+data_width_p  command message {data, header}; hdr_w = paddr_width_p+7.
- mem_cmd_v_i  in  1  command valid.
- mem_cmd_ready_and_o  out  1  command ready; transfer occurs when v and ready are both high.
- mem_resp_o  out  hdr_w+data_width_p  response message {data, header}.
- mem_resp_v_o  out  1  response valid.
- mem_resp_yumi_i  in  1  consumer accepts the response; asserted only while v_o is high.

Header layout:
- [3:0] msg_type: 0=RD (block read), 1=WR (block write), 2=UC_RD, 3=UC_WR.
- [paddr_width_p+3:4] addr.
- [paddr_width_p+6:paddr_width_p+4] size, encoding 2^size bytes.

Behaviour:
- Reset: clk_i is the only clock. reset_n_i is asynchronous and active-low. While reset is low: queue empty, all countdowns 0, mem_resp_v_o=0, mem_cmd_ready_and_o=0. Memory array is not reset; its contents survive reset.
- Reset deassert: on the first clock edge after deassertion, mem_cmd_ready_and_o becomes 1.
- Reset mid-operation: every outstanding command is dropped and no response is produced for it. Writes already accepted before reset remain in memory.
- Address decode: off_w = log2(data_width_p/8). Memory index = addr[off_w +: log2(mem_els_p)]. Upper address bits are ignored, so addresses wrap.
- Memory access timing: memory is accessed in the acceptance cycle. A write commits at the clock edge that accepts it. Read data is sampled combinationally from the pre-write array contents and stored in the queue entry.
- RD: entry data = mem[idx].
- WR: mem[idx] <= cmd data; entry data = 0.
- UC_WR: n = 2^size bytes, or a full block if n >= data_width_p/8. Byte offset = addr[off_w-1:0] aligned down to n. Only those n bytes are written, taken from cmd data bits [8n-1:0]. Entry data = 0.
- UC_RD: entry data = mem[idx], whole block, unshifted.
- msg_type 4..15: no memory effect; entry data = 0; response still returned.
- Response header: equals the command header bit-for-bit.
- Queue: circular FIFO of els_p entries, each holding {header, data, countdown}. Read and write pointers wrap modulo els_p. Occupancy count is log2(els_p)+1 bits.
- Command ready: mem_cmd_ready_and_o = (count < els_p). It is registered-state-only and does not depend on same-cycle mem_resp_yumi_i, so a full queue with a simultaneous yumi still shows ready=0 that cycle.
- Countdown: set to latency_p-1 at enqueue. Every valid entry with a nonzero countdown decrements each cycle, regardless of its queue position. The countdown saturates at 0.
- Response valid: mem_resp_v_o = head valid and head countdown == 0. A command accepted in cycle t produces a response no earlier than cycle t+latency_p; it is exactly t+latency_p if the queue ahead of it has drained.
- Response hold: mem_resp_o is held stable while v_o=1 and yumi=0. Yumi pops the head at that edge.
- Simultaneous enqueue and dequeue: both occur; count is unchanged.
- Backpressure: an entry that reaches countdown 0 waits indefinitely. Later entries also reach 0 and then issue back-to-back, one per cycle, once yumi resumes.
- Assertions (simulation only): yumi while !v_o is an error; latency_p < 1 or els_p < 2 is an error.

Test Plan:
- Block round trip: reset, then WR addr 0x80 with data = 512'hA5..A5, then RD addr 0x80 → RD response in cycle accept+8 with data A5..A5 and header equal to the command header; WR response data = 0.
- Byte merge: WR addr 0x0 with all 0s; UC_WR addr 0x13, size=0, data[7:0]=0x5C; RD 0x0 → byte 0x13 = 0x5C, all other bytes 0. Then UC_WR addr 0x17, size=2 → 4 bytes written at offset 0x14–0x17.
- Full and backpressure: hold yumi=0 and issue 4 RDs back-to-back → ready drops to 0 after the 4th acceptance, stays 0, and a 5th command is not taken. Release yumi → 4 responses on consecutive cycles in issue order; ready returns the cycle after the first pop.
- Latency 1 streaming: latency_p=1, yumi tied to v, 10 commands on consecutive cycles → each response appears exactly 1 cycle after its acceptance; throughput 1 per cycle with no bubbles.
- Address wrap: mem_els_p=1024, WR addr 0x10000 (index 0), RD addr 0x0 → returns the written data.
- Mid-operation reset: 3 RDs outstanding, pulse reset_n_i low for 2 cycles asynchronously (not clock-aligned) → v_o falls immediately, no stale responses after release, and an earlier WR's data is still readable.

Source files
------------

// File: rtl/bp_lite_mem_latency_model_if.sv
`default_nettype none
// ------------------------------------------------------------------
// bp_lite_mem_latency_model_if : command/response bus for the memory model
// Revision 1.0 - initial release
// ------------------------------------------------------------------
interface bp_lite_mem_latency_model_if #(
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 512
);
  localparam int msg_w = paddr_width_p + 7 + data_width_p;

  logic [msg_w-1:0] mem_cmd_i;
  logic             mem_cmd_v_i;
  logic             mem_cmd_ready_and_o;
  logic [msg_w-1:0] mem_resp_o;
  logic             mem_resp_v_o;
  logic             mem_resp_yumi_i;

  modport master (
    output mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
    input  mem_cmd_ready_and_o, mem_resp_o, mem_resp_v_o
  );

  modport slave (
    input  mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
    output mem_cmd_ready_and_o, mem_resp_o, mem_resp_v_o
  );
endinterface
`default_nettype wire

// File: rtl/bp_lite_mem_latency_model.sv
`default_nettype none
// ------------------------------------------------------------------
// bp_lite_mem_latency_model : block memory endpoint with in-order fixed-latency responses
// Revision 1.0 - initial release
// ------------------------------------------------------------------
module bp_lite_mem_latency_model #(
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 512,
  parameter int mem_els_p     = 1024,
  parameter int els_p         = 4,
  parameter int latency_p     = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  bp_lite_mem_latency_model_if.slave  mem_if
);
  localparam int hdr_w   = paddr_width_p + 7;
  localparam int msg_w   = hdr_w + data_width_p;
  localparam int bytes_w = data_width_p / 8;
  localparam int off_w   = $clog2(bytes_w);
  localparam int idx_w   = $clog2(mem_els_p);
  localparam int ptr_w   = $clog2(els_p);
  localparam int cnt_w   = ptr_w + 1;
  localparam int cd_w    = (latency_p > 1) ? $clog2(latency_p) : 1;

  logic [hdr_w-1:0]         cmd_hdr;
  logic [data_width_p-1:0]  cmd_data;
  logic [3:0]               cmd_type;
  logic [paddr_width_p-1:0] cmd_addr;
  logic [2:0]               cmd_size;
  logic [idx_w-1:0]         cmd_idx;
  logic [off_w-1:0]         cmd_off;
  logic                     unused_addr_bits;

  assign cmd_hdr          = mem_if.mem_cmd_i[hdr_w-1:0];
  assign cmd_data         = mem_if.mem_cmd_i[msg_w-1:hdr_w];
  assign cmd_type         = cmd_hdr[3:0];
  assign cmd_addr         = cmd_hdr[paddr_width_p+3:4];
  assign cmd_size         = cmd_hdr[paddr_width_p+6:paddr_width_p+4];
  assign cmd_idx          = cmd_addr[off_w +: idx_w];
  assign cmd_off          = cmd_addr[off_w-1:0];
  assign unused_addr_bits = ^cmd_addr[paddr_width_p-1:off_w+idx_w];

  logic [data_width_p-1:0] mem_q [mem_els_p];

  logic [hdr_w-1:0]        hdr_q  [els_p];
  logic [data_width_p-1:0] data_q [els_p];
  logic [cd_w-1:0]         cd_q   [els_p];
  logic [els_p-1:0]        vld_q;
  logic [ptr_w-1:0]        wptr_q, rptr_q;
  logic [cnt_w-1:0]        count_q, count_d;
  logic                    ready_q;

  logic cmd_fire, resp_v, resp_fire;
  assign cmd_fire  = mem_if.mem_cmd_v_i & ready_q;
  assign resp_v    = vld_q[rptr_q] & (cd_q[rptr_q] == '0);
  assign resp_fire = mem_if.mem_resp_yumi_i & resp_v;

  // Uncached write: n = 2^size bytes at an n-aligned offset, widened to a full block when n covers it
  int                      uc_n, uc_base;
  logic                    uc_full;
  logic [data_width_p-1:0] uc_bit_mask, uc_wdata;
  always_comb begin
    uc_n        = 1 << cmd_size;
    uc_full     = (uc_n >= bytes_w);
    uc_base     = uc_full ? 0 : (int'(cmd_off) & ~(uc_n - 1));
    uc_bit_mask = '0;
    for (int b = 0; b < bytes_w; b++) begin
      if (uc_full || ((b >= uc_base) && (b < uc_base + uc_n))) uc_bit_mask[b*8 +: 8] = 8'hFF;
    end
    uc_wdata = cmd_data << (uc_base * 8);
  end

  logic [data_width_p-1:0] rd_data, wr_data, entry_data;
  logic                    wr_en;
  assign rd_data = mem_q[cmd_idx];

  always_comb begin
    wr_en      = 1'b0;
    wr_data    = cmd_data;
    entry_data = '0;
    if (cmd_fire) begin
      case (cmd_type)
        4'd0, 4'd2: entry_data = rd_data;
        4'd1:       wr_en = 1'b1;
        4'd3: begin
          wr_en   = 1'b1;
          wr_data = (rd_data & ~uc_bit_mask) | (uc_wdata & uc_bit_mask);
        end
        default: ;
      endcase
    end
  end

  // Memory and entry payloads are deliberately unreset so contents survive a reset pulse
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[cmd_idx] <= wr_data;
    if (cmd_fire) begin
      hdr_q[wptr_q]  <= cmd_hdr;
      data_q[wptr_q] <= entry_data;
    end
  end

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count_d = count_q;
    if (cmd_fire && !resp_fire)      count_d = count_q + 1'b1;
    else if (!cmd_fire && resp_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i < els_p; i++) cd_q[i] <= '0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d < cnt_w'(els_p));
      if (cmd_fire)  wptr_q <= next_ptr(wptr_q);
      if (resp_fire) rptr_q <= next_ptr(rptr_q);
      for (int i = 0; i < els_p; i++) begin
        if (cmd_fire && (wptr_q == ptr_w'(i))) begin
          vld_q[i] <= 1'b1;
          cd_q[i]  <= cd_w'(latency_p - 1);
        end else begin
          if (resp_fire && (rptr_q == ptr_w'(i))) vld_q[i] <= 1'b0;
          if (vld_q[i] && (cd_q[i] != '0))       cd_q[i]  <= cd_q[i] - 1'b1;
        end
      end
    end
  end

  assign mem_if.mem_cmd_ready_and_o = ready_q;
  assign mem_if.mem_resp_v_o        = resp_v;
  assign mem_if.mem_resp_o          = {data_q[rptr_q], hdr_q[rptr_q]};

`ifndef SYNTHESIS
  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    mem_if.mem_resp_yumi_i |-> resp_v);
  a_params_legal: assert property (@(posedge clk_i) (latency_p >= 1) && (els_p >= 2));
`endif

endmodule
`default_nettype wire
